// File: rtl/cache_write_buffer.sv
// cache_write_buffer: write-through posting buffer between the cache RAM-side
// port and the backing RAM. Cache writes are queued in a small FIFO and
// drained to RAM one at a time with a mem_we/mem_ack handshake. Cache miss
// reads look up rd_addr in the FIFO so a read never sees data older than a
// posted write.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wr_valid/wr_addr/wr_data cache write post; wr_ready = buffer can accept
//   rd_addr -> rd_hit/rd_data forwarding lookup (combinational, youngest wins)
//   mem_we/mem_addr/mem_data registered RAM write request, held until mem_ack
//   count/empty/full         occupancy status
//
// Optional feature macro: WB_COALESCE_EN
//   Defined: a push matching a buffered non-head entry while draining
//   overwrites that entry's data in place, even when the buffer is full.
//   Undefined: every accepted push allocates a new entry.
module cache_write_buffer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RAM_DEPTH = 256,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    input  logic [$clog2(RAM_DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    output logic                         wr_ready,
    input  logic [$clog2(RAM_DEPTH)-1:0] rd_addr,
    output logic                         rd_hit,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         mem_we,
    output logic [$clog2(RAM_DEPTH)-1:0] mem_addr,
    output logic [WIDTH-1:0]             mem_data,
    input  logic                         mem_ack,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned AW = $clog2(RAM_DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    state_t           state;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    head_nxt;
    logic             co_hit;
    logic [PW-1:0]    co_idx;
    logic             push;
    logic             coal;
    logic             pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign head_nxt = PW'(head + PW'(1));

    // Forwarding: walk from oldest to youngest so the youngest match wins.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[PW'(head + PW'(i))] && (addr_q[PW'(head + PW'(i))] == rd_addr)) begin
                rd_hit  = 1'b1;
                rd_data = data_q[PW'(head + PW'(i))];
            end
        end
    end

`ifdef WB_COALESCE_EN
    // Coalesce lookup: only non-head entries, only while the head is draining.
    always_comb begin
        co_hit = 1'b0;
        co_idx = head;
        if (state == S_WRITE) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (valid_q[PW'(head + PW'(i))] && (addr_q[PW'(head + PW'(i))] == wr_addr)) begin
                    co_hit = 1'b1;
                    co_idx = PW'(head + PW'(i));
                end
            end
        end
    end

    assign wr_ready = !full || co_hit;
`else
    assign co_hit   = 1'b0;
    assign co_idx   = head;
    assign wr_ready = !full;
`endif

    assign push = wr_valid && wr_ready && !co_hit;
    assign coal = wr_valid && co_hit;
    assign pop  = (state == S_WRITE) && mem_ack;

    // FIFO storage, pointers and drain FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            valid_q  <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_q[tail]  <= wr_addr;
                data_q[tail]  <= wr_data;
                valid_q[tail] <= 1'b1;
                tail          <= PW'(tail + PW'(1));
            end
            if (coal) begin
                data_q[co_idx] <= wr_data;
            end
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head_nxt;
            end
            count <= CW'(count + CW'(push) - CW'(pop));

            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        mem_we   <= 1'b1;
                        mem_addr <= addr_q[head];
                        mem_data <= data_q[head];
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        if (count > CW'(1)) begin
                            // Next entry already buffered; bypass a same-edge coalesce into it.
                            mem_addr <= addr_q[head_nxt];
                            mem_data <= (coal && (co_idx == head_nxt)) ? wr_data : data_q[head_nxt];
                        end else if (push) begin
                            // Last entry leaves as a new one arrives: it becomes the next head.
                            mem_addr <= wr_addr;
                            mem_data <= wr_data;
                        end else begin
                            mem_we <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Testbench for cache_write_buffer: directed scenarios followed by random
// traffic, all checked against a queue-based model of the posting buffer.
module tb_cache_write_buffer;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned RAM_DEPTH = 256;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned AW        = 8;
    localparam int unsigned CW        = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic [AW-1:0]    rd_addr;
    logic             rd_hit;
    logic [WIDTH-1:0] rd_data;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic             mem_ack;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;

    cache_write_buffer #(
        .WIDTH(WIDTH), .RAM_DEPTH(RAM_DEPTH), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t q[$];      // model: buffered writes, oldest first
    ent_t wlog[$];   // writes the RAM actually accepted
    bit   draining;  // model: a RAM request for q[0] is outstanding
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest non-head entry a push would merge into, or -1.
    function automatic int coal_idx();
`ifdef WB_COALESCE_EN
        if (draining) begin
            for (int i = q.size() - 1; i >= 1; i--)
                if (q[i].a == wr_addr) return i;
        end
`endif
        return -1;
    endfunction

    task automatic check_comb();
        bit             exp_hit;
        logic [7:0]     exp_d;
        bit             exp_ready;
        exp_ready = (q.size() < DEPTH) || (coal_idx() >= 0);
        exp_hit   = 1'b0;
        exp_d     = '0;
        foreach (q[i]) if (q[i].a == rd_addr) begin exp_hit = 1'b1; exp_d = q[i].d; end
        chk("wr_ready", 32'(wr_ready), 32'(exp_ready));
        chk("full",     32'(full),     32'(q.size() == DEPTH));
        chk("empty",    32'(empty),    32'(q.size() == 0));
        chk("rd_hit",   32'(rd_hit),   32'(exp_hit));
        chk("rd_data",  32'(rd_data),  32'(exp_d));
    endtask

    task automatic check_regs();
        chk("mem_we", 32'(mem_we), 32'(draining));
        chk("count",  32'(count),  32'(q.size()));
        if (draining && q.size() > 0) begin
            chk("mem_addr", 32'(mem_addr), 32'(q[0].a));
            chk("mem_data", 32'(mem_data), 32'(q[0].d));
        end
    endtask

    // Apply one clock edge to the model using the inputs seen at that edge.
    task automatic model_edge();
        int   ci;
        bit   ready;
        bit   was_ne;
        ent_t e;
        ci     = coal_idx();
        ready  = (q.size() < DEPTH) || (ci >= 0);
        was_ne = (q.size() > 0);
        if (wr_valid && ci >= 0) q[ci].d = wr_data;
        if (draining && mem_ack) void'(q.pop_front());
        if (wr_valid && ready && ci < 0) begin
            e.a = wr_addr;
            e.d = wr_data;
            q.push_back(e);
        end
        if (draining) begin
            if (mem_ack) draining = (q.size() > 0);
        end else if (was_ne) begin
            draining = 1'b1;
        end
    endtask

    task automatic tick();
        ent_t e;
        #1;
        check_comb();
        if (mem_we && mem_ack) begin
            e.a = mem_addr;
            e.d = mem_data;
            wlog.push_back(e);
        end
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] d, input logic ack);
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        mem_ack  = ack;
        tick();
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [7:0] a, input logic [7:0] d);
        ent_t e;
        e = '0;
        if (idx < wlog.size()) e = wlog[idx];
        chk({tag, "_addr"}, 32'(e.a), 32'(a));
        chk({tag, "_data"}, 32'(e.d), 32'(d));
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        mem_ack  = 1'b0;
        draining = 1'b0;

        // Reset state
        #2;
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data", 32'(mem_data), 32'd0);
        chk("rst_rd_hit",   32'(rd_hit),   32'd0);
        chk("rst_rd_data",  32'(rd_data),  32'd0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single write with mem_ack tied high
        drive(1'b1, 8'h12, 8'hA5, 1'b1);
        chk("single_we_edge1", 32'(mem_we), 32'd0);
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        chk("single_we_edge2", 32'(mem_we),   32'd1);
        chk("single_addr",     32'(mem_addr), 32'h12);
        chk("single_data",     32'(mem_data), 32'hA5);
        drive(1'b0, 8'h00, 8'h00, 1'b1);
        chk("single_we_drop",  32'(mem_we), 32'd0);
        chk("single_empty",    32'(empty),  32'd1);

        // Fill and stall, then drain in order
        for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 8'(i * 16), 1'b0);
        chk("fill_full",     32'(full),     32'd1);
        chk("fill_wr_ready", 32'(wr_ready), 32'd0);
        drive(1'b1, 8'h05, 8'h50, 1'b0);
        chk("fill_5th_dropped", 32'(count), 32'd4);
        wlog.delete();
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 8'h00, 1'b1);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_n", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_log("drain", i, 8'(i + 1), 8'((i + 1) * 16));
        drive(1'b0, 8'h00, 8'h00, 1'b0);

        // Forwarding of the youngest match
        drive(1'b1, 8'h20, 8'h11, 1'b0);
        drive(1'b1, 8'h20, 8'h22, 1'b0);
        wr_valid = 1'b0;
        rd_addr  = 8'h20;
        #1;
        chk("fwd_hit",  32'(rd_hit),  32'd1);
        chk("fwd_data", 32'(rd_data), 32'h22);
        rd_addr = 8'h21;
        #1;
        chk("fwd_miss_hit",  32'(rd_hit),  32'd0);
        chk("fwd_miss_data", 32'(rd_data), 32'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 8'h00, 1'b1);

        // Push and pop on the same edge
        drive(1'b1, 8'h30, 8'h01, 1'b0);
        drive(1'b1, 8'h31, 8'h02, 1'b0);
        wlog.delete();
        drive(1'b1, 8'h32, 8'h03, 1'b1);
        chk("pushpop_count", 32'(count), 32'd2);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 8'h00, 1'b1);
        chk("pushpop_n", 32'(wlog.size()), 32'd3);
        chk_log("pushpop0", 0, 8'h30, 8'h01);
        chk_log("pushpop2", 2, 8'h32, 8'h03);

        // Reset while draining
        drive(1'b1, 8'h40, 8'h0A, 1'b0);
        drive(1'b1, 8'h41, 8'h0B, 1'b0);
        drive(1'b1, 8'h42, 8'h0C, 1'b0);
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        wr_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_we",    32'(mem_we), 32'd0);
        chk("midrst_count", 32'(count),  32'd0);
        chk("midrst_empty", 32'(empty),  32'd1);
        q.delete();
        draining = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Same-address pushes while draining
        wlog.delete();
        drive(1'b1, 8'h05, 8'h01, 1'b0);
        drive(1'b1, 8'h06, 8'h02, 1'b0);
        drive(1'b1, 8'h06, 8'h03, 1'b0);
`ifdef WB_COALESCE_EN
        chk("coal_count", 32'(count), 32'd2);
`else
        chk("coal_count", 32'(count), 32'd3);
`endif
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 8'h00, 1'b1);
        chk_log("coal0", 0, 8'h05, 8'h01);
`ifdef WB_COALESCE_EN
        chk("coal_n", 32'(wlog.size()), 32'd2);
        chk_log("coal1", 1, 8'h06, 8'h03);
`else
        chk("coal_n", 32'(wlog.size()), 32'd3);
        chk_log("coal1", 1, 8'h06, 8'h02);
        chk_log("coal2", 2, 8'h06, 8'h03);
`endif

        // Random traffic over a small address window to exercise hits
        for (int n = 0; n < 400; n++) begin
            rd_addr = 8'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
                  8'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 8'h00, 1'b1);
        chk("final_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
